// File: rtl/snake_grid_renderer.sv
// Snake playfield RAM scanned out as 2-bit cell codes for the VGA path; updates land in blanking.
// Optional: define SNAKE_BORDER_EN to force the outer ring of cells to display as wall (11).
module snake_grid_renderer #(
    parameter int unsigned CELL_LOG2 = 4,
    parameter int unsigned GRID_W    = 40,
    parameter int unsigned GRID_H    = 30,
    parameter int unsigned V_ACTIVE  = 480
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       wr_valid,
    output logic       wr_ready,
    input  logic [5:0] wr_col,
    input  logic [4:0] wr_row,
    input  logic [1:0] wr_code,
    input  logic       clear_req,
    output logic       clear_busy,
    output logic       frame_start,
    output logic [1:0] color_data,
    output logic       game_enable
);
    localparam int unsigned Cells    = GRID_W * GRID_H;
    localparam logic [10:0] LastAddr = 11'(Cells - 1);

    typedef enum logic [0:0] {StClear, StIdle} state_e;

    state_e      state_q, state_d;
    logic [10:0] clr_addr_q, clr_addr_d;

    logic [1:0]  mem [Cells];

    // S0: scan coordinate to cell address
    logic [9:0]  x_cell, y_cell;
    logic        inrange_s0;
    logic [10:0] rd_addr;

    always_comb begin
        x_cell     = X >> CELL_LOG2;
        y_cell     = Y >> CELL_LOG2;
        inrange_s0 = (32'(x_cell) < GRID_W) && (32'(y_cell) < GRID_H);
        rd_addr    = (11'(y_cell) << 5) + (11'(y_cell) << 3) + 11'(x_cell);
        // Keep the RAM index in bounds for off-grid pixels
        if (!inrange_s0) begin
            rd_addr = '0;
        end
    end

`ifdef SNAKE_BORDER_EN
    logic border_s0, border_s1;
    assign border_s0 = (x_cell == '0) || (y_cell == '0) ||
                       (32'(x_cell) == GRID_W - 1) || (32'(y_cell) == GRID_H - 1);
`endif

    // Write side
    logic        wr_inrange, blank;
    logic [10:0] wr_addr;
    logic        mem_we;
    logic [10:0] mem_waddr;
    logic [1:0]  mem_wdata;

    always_comb begin
        wr_inrange = (32'(wr_col) < GRID_W) && (32'(wr_row) < GRID_H);
        wr_addr    = ({6'b0, wr_row} << 5) + ({6'b0, wr_row} << 3) + {5'b0, wr_col};
        blank      = 32'(Y) >= V_ACTIVE;
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        wr_ready   = 1'b0;
        clear_busy = 1'b0;
        mem_we     = 1'b0;
        mem_waddr  = wr_addr;
        mem_wdata  = wr_code;
        unique case (state_q)
            StClear: begin
                clear_busy = 1'b1;
                mem_we     = 1'b1;
                mem_waddr  = clr_addr_q;
                mem_wdata  = 2'b00;
                clr_addr_d = clr_addr_q + 11'd1;
                if (clr_addr_q == LastAddr) begin
                    state_d = StIdle;
                end
            end
            StIdle: begin
                wr_ready = blank;
                // A clear beats a coincident write; off-grid writes are consumed silently
                if (clear_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else if (wr_valid && blank && wr_inrange) begin
                    mem_we = 1'b1;
                end
            end
            default: begin
                state_d    = StClear;
                clr_addr_d = '0;
            end
        endcase
    end

    // RAM: separate write port, registered read (S1)
    logic [1:0] rd_data_s1;

    always_ff @(posedge clock_25) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_s1 <= mem[rd_addr];
    end

    logic inrange_s1, busy_s1;

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            state_q     <= StClear;
            clr_addr_q  <= '0;
            inrange_s1  <= 1'b0;
            busy_s1     <= 1'b0;
            color_data  <= 2'b00;
            game_enable <= 1'b0;
            frame_start <= 1'b0;
`ifdef SNAKE_BORDER_EN
            border_s1   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_addr_q  <= clr_addr_d;
            inrange_s1  <= inrange_s0;
            busy_s1     <= clear_busy;
            game_enable <= inrange_s1 & ~busy_s1;
            frame_start <= (X == '0) && (32'(Y) == V_ACTIVE);
`ifdef SNAKE_BORDER_EN
            border_s1   <= border_s0;
            color_data  <= inrange_s1 ? (border_s1 ? 2'b11 : rd_data_s1) : 2'b00;
`else
            color_data  <= inrange_s1 ? rd_data_s1 : 2'b00;
`endif
        end
    end

endmodule
